// File: rtl/bus_tx_fifo_pkg.sv
// Shared register map for the bus transmit FIFO: register offsets,
// STATUS/CTRL bit positions and the STATUS byte builder.
package bus_tx_fifo_pkg;

    typedef enum logic [7:0] {
        REG_DATA = 8'd0,
        REG_STAT = 8'd1
    } reg_off_e;

    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 7;

    localparam int CTRL_FLUSH   = 0;
    localparam int CTRL_OVF_CLR = 7;

    function automatic logic [7:0] make_status(input logic ovf, input logic full,
                                               input logic empty);
        logic [7:0] s;
        s            = '0;
        s[STAT_OVF]  = ovf;
        s[STAT_FULL] = full;
        s[STAT_EMPTY] = empty;
        return s;
    endfunction

endpackage

// File: rtl/bus_tx_fifo_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO is accepted only when
// a pop frees the slot on the same edge, otherwise it is dropped and flagged.
module sync_fifo #(
    parameter int Width     = 8,
    parameter int DepthLog2 = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    input  logic [Width-1:0]     din,
    output logic                 full,
    output logic                 empty,
    output logic [DepthLog2:0]   count,
    output logic [Width-1:0]     head,
    output logic                 overflow
);

    localparam int Depth = 1 << DepthLog2;
    localparam logic [DepthLog2:0] FullCount = {1'b1, {DepthLog2{1'b0}}};

    logic [Width-1:0]     mem_q [Depth];
    logic [DepthLog2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DepthLog2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DepthLog2:0]   count_q, count_d;
    logic                 push_ok, pop_ok, wr_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == FullCount);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        overflow = push & full & ~pop_ok & ~flush;
        wr_en    = push_ok & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Flush overrides any push or pop arriving on the same edge.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + DepthLog2'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + DepthLog2'(1);
            count_d = count_q + {{DepthLog2{1'b0}}, push_ok}
                              - {{DepthLog2{1'b0}}, pop_ok};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/bus_tx_fifo.sv
// Memory-mapped transmit FIFO: bus decode, registered read-back with a
// tri-state driver, sticky overflow flag and a valid/ready output stream.
module bus_tx_fifo
    import bus_tx_fifo_pkg::*;
#(
    parameter logic [7:0] BaseAddr  = 8'hC0,
    parameter int         DepthLog2 = 3
) (
    input  logic       CLK,
    input  logic       RESETN,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    output logic [7:0] TX_DATA,
    output logic       TX_VALID,
    input  logic       TX_READY,
    output logic       DBG_BUS_OE
);

    localparam logic [7:0] DataAddr = BaseAddr + REG_DATA;
    localparam logic [7:0] StatAddr = BaseAddr + REG_STAT;

    logic               sel_data, sel_stat;
    logic               push, pop, flush, ovf_clr;
    logic               full, empty, overflow;
    logic [DepthLog2:0] count;
    logic [7:0]         head;
    logic               bus_oe;

    logic               drive_en_q, drive_en_d;
    logic [7:0]         rd_data_q, rd_data_d;
    logic               ovf_q, ovf_d;

    always_comb begin
        sel_data = (BUS_ADDR == DataAddr);
        sel_stat = (BUS_ADDR == StatAddr);
        push     = BUS_WE & sel_data;
        flush    = BUS_WE & sel_stat & BUS_DATA[CTRL_FLUSH];
        ovf_clr  = BUS_WE & sel_stat & BUS_DATA[CTRL_OVF_CLR];
        pop      = TX_VALID & TX_READY;
    end

    // Read data is captured from pre-edge state, so it reflects the FIFO
    // before this edge's push/pop/flush.
    always_comb begin
        drive_en_d = ~BUS_WE & (sel_data | sel_stat);
        rd_data_d  = rd_data_q;
        if (drive_en_d) begin
            rd_data_d = sel_data ? 8'(count) : make_status(ovf_q, full, empty);
        end
        ovf_d = ovf_q;
        if (ovf_clr)  ovf_d = 1'b0;
        if (overflow) ovf_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            drive_en_q <= 1'b0;
            rd_data_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            drive_en_q <= drive_en_d;
            rd_data_q  <= rd_data_d;
            ovf_q      <= ovf_d;
        end
    end

    sync_fifo #(
        .Width     (8),
        .DepthLog2 (DepthLog2)
    ) u_fifo (
        .clk      (CLK),
        .rst_n    (RESETN),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .din      (BUS_DATA),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .head     (head),
        .overflow (overflow)
    );

    // A write cycle right after a read must not see our driver still on.
    assign bus_oe     = drive_en_q & ~BUS_WE;
    assign BUS_DATA   = bus_oe ? rd_data_q : 8'hzz;
    assign DBG_BUS_OE = bus_oe;
    assign TX_VALID   = ~empty;
    assign TX_DATA    = head;

endmodule

// File: tb/tb_bus_tx_fifo.sv
// Directed bench for bus_tx_fifo: bus read/write driver tasks plus one task
// per scenario, each comparing against hand-computed values.
module tb_bus_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] bus_addr = 8'h00;
    logic       bus_we = 1'b0;
    logic [7:0] tb_drv = 8'h00;
    logic       tb_drv_en = 1'b0;
    logic       tx_ready = 1'b0;
    wire  [7:0] bus_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       bus_oe;

    int checks = 0;
    int errors = 0;

    assign bus_data = tb_drv_en ? tb_drv : 8'hzz;

    always #5 clk = ~clk;

    bus_tx_fifo #(.BaseAddr(8'hC0), .DepthLog2(3)) dut (
        .CLK        (clk),
        .RESETN     (rst_n),
        .BUS_DATA   (bus_data),
        .BUS_ADDR   (bus_addr),
        .BUS_WE     (bus_we),
        .TX_DATA    (tx_data),
        .TX_VALID   (tx_valid),
        .TX_READY   (tx_ready),
        .DBG_BUS_OE (bus_oe)
    );

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_addr = a; bus_we = 1'b1; tb_drv = d; tb_drv_en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic bus_idle();
        @(negedge clk);
        bus_addr = 8'h00; bus_we = 1'b0; tb_drv_en = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output logic oe);
        @(negedge clk);
        bus_addr = a; bus_we = 1'b0; tb_drv_en = 1'b0;
        @(posedge clk); #1;
        d  = bus_data;
        oe = bus_oe;
    endtask

    task automatic test_reset();
        logic [7:0] d; logic oe;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        checks++; if (bus_oe !== 1'b0) begin errors++; $display("FAIL reset_bus_oe: got %b expected 0", bus_oe); end
        @(negedge clk) rst_n = 1'b1;
        bus_read(8'hC1, d, oe);
        checks++; if ({oe, d} !== {1'b1, 8'h01}) begin errors++; $display("FAIL reset_status: got oe=%b %h expected oe=1 01", oe, d); end
        bus_read(8'hC0, d, oe);
        checks++; if ({oe, d} !== {1'b1, 8'h00}) begin errors++; $display("FAIL reset_count: got oe=%b %h expected oe=1 00", oe, d); end
        bus_write(8'hC0, 8'h5A);
        bus_read(8'hC1, d, oe);
        checks++; if ({oe, d, tx_valid} !== {1'b1, 8'h00, 1'b1}) begin errors++; $display("FAIL midreset_pre: got oe=%b %h v=%b expected oe=1 00 v=1", oe, d, tx_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({tx_valid, bus_oe} !== 2'b00) begin errors++; $display("FAIL midreset_async: got v=%b oe=%b expected 0 0", tx_valid, bus_oe); end
        @(negedge clk);
        rst_n = 1'b1; bus_addr = 8'h00;
        bus_read(8'hC1, d, oe);
        checks++; if ({oe, d} !== {1'b1, 8'h01}) begin errors++; $display("FAIL midreset_status: got oe=%b %h expected oe=1 01", oe, d); end
    endtask

    task automatic test_ordering();
        logic [7:0] d; logic oe;
        bus_write(8'hC0, 8'hA5);
        bus_write(8'hC0, 8'h3C);
        bus_idle(); #1;
        checks++; if ({tx_valid, tx_data} !== {1'b1, 8'hA5}) begin errors++; $display("FAIL order_head: got %h expected 1a5", {tx_valid, tx_data}); end
        bus_read(8'hC0, d, oe);
        checks++; if ({oe, d} !== {1'b1, 8'h02}) begin errors++; $display("FAIL order_count: got oe=%b %h expected oe=1 02", oe, d); end
        bus_idle();
        tx_ready = 1'b1; #1;
        checks++; if ({tx_valid, tx_data} !== {1'b1, 8'hA5}) begin errors++; $display("FAIL order_first: got %h expected 1a5", {tx_valid, tx_data}); end
        @(posedge clk); #1;
        checks++; if ({tx_valid, tx_data} !== {1'b1, 8'h3C}) begin errors++; $display("FAIL order_second: got %h expected 13c", {tx_valid, tx_data}); end
        @(posedge clk); #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL order_empty: got %b expected 0", tx_valid); end
        @(negedge clk) tx_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [7:0] d; logic oe; logic [7:0] v;
        for (int i = 0; i < 9; i++) begin
            v = 8'h10 + 8'(i);
            bus_write(8'hC0, v);
        end
        bus_read(8'hC1, d, oe);
        checks++; if (d !== 8'h82) begin errors++; $display("FAIL ovf_status: got %h expected 82", d); end
        bus_read(8'hC0, d, oe);
        checks++; if (d !== 8'h08) begin errors++; $display("FAIL ovf_count: got %h expected 08", d); end
        bus_write(8'hC1, 8'h80);
        bus_read(8'hC1, d, oe);
        checks++; if (d !== 8'h02) begin errors++; $display("FAIL ovf_clear: got %h expected 02", d); end
        bus_idle();
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            v = 8'h10 + 8'(i);
            checks++; if ({tx_valid, tx_data} !== {1'b1, v}) begin errors++; $display("FAIL ovf_drain[%0d]: got %h expected %h", i, {tx_valid, tx_data}, {1'b1, v}); end
            @(negedge clk);
        end
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL ovf_ninth_absent: got valid=%b data=%h expected valid 0", tx_valid, tx_data); end
        tx_ready = 1'b0;
        bus_read(8'hC1, d, oe);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL ovf_after_drain: got %h expected 01", d); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] d; logic oe; logic [7:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 8'h20 + 8'(i);
            bus_write(8'hC0, v);
        end
        bus_read(8'hC1, d, oe);
        checks++; if (d !== 8'h02) begin errors++; $display("FAIL fpp_full: got %h expected 02", d); end
        @(negedge clk);
        bus_addr = 8'hC0; bus_we = 1'b1; tb_drv = 8'h77; tb_drv_en = 1'b1; tx_ready = 1'b1;
        @(posedge clk); #1;
        bus_idle();
        tx_ready = 1'b0;
        bus_read(8'hC1, d, oe);
        checks++; if (d !== 8'h02) begin errors++; $display("FAIL fpp_no_ovf: got %h expected 02", d); end
        bus_read(8'hC0, d, oe);
        checks++; if (d !== 8'h08) begin errors++; $display("FAIL fpp_count: got %h expected 08", d); end
        bus_idle();
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            v = (i < 7) ? 8'h21 + 8'(i) : 8'h77;
            checks++; if ({tx_valid, tx_data} !== {1'b1, v}) begin errors++; $display("FAIL fpp_drain[%0d]: got %h expected %h", i, {tx_valid, tx_data}, {1'b1, v}); end
            @(negedge clk);
        end
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty: got %b expected 0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic [7:0] d; logic oe;
        bus_write(8'hC0, 8'h31);
        bus_write(8'hC0, 8'h32);
        bus_write(8'hC0, 8'h33);
        @(negedge clk);
        bus_addr = 8'hC1; bus_we = 1'b1; tb_drv = 8'h01; tb_drv_en = 1'b1; tx_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL flush_pop_valid: got %b expected 0", tx_valid); end
        bus_idle();
        tx_ready = 1'b0;
        bus_read(8'hC1, d, oe);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL flush_status: got %h expected 01", d); end
        bus_read(8'hC0, d, oe);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL flush_count: got %h expected 00", d); end
        bus_write(8'hC0, 8'h11);
        bus_write(8'hC1, 8'h01);
        bus_idle(); #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL flush2_valid: got %b expected 0", tx_valid); end
        bus_read(8'hC1, d, oe);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL flush2_status: got %h expected 01", d); end
        bus_write(8'hC0, 8'h44);
        bus_idle(); #1;
        checks++; if ({tx_valid, tx_data} !== {1'b1, 8'h44}) begin errors++; $display("FAIL flush_reuse_head: got %h expected 144", {tx_valid, tx_data}); end
        bus_read(8'hC0, d, oe);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL flush_reuse_count: got %h expected 01", d); end
        bus_write(8'hC1, 8'h01);
    endtask

    task automatic test_bus_hygiene();
        logic [7:0] d; logic oe;
        logic [7:0] addrs [3];
        addrs[0] = 8'h00; addrs[1] = 8'hC2; addrs[2] = 8'hBF;
        bus_write(8'hC0, 8'h55);
        bus_write(8'hC0, 8'h66);
        for (int i = 0; i < 3; i++) begin
            bus_read(addrs[i], d, oe);
            checks++; if (oe !== 1'b0) begin errors++; $display("FAIL hyg_read_oe[%h]: got %b expected 0", addrs[i], oe); end
            bus_write(addrs[i], 8'h81);
        end
        bus_read(8'hC0, d, oe);
        checks++; if (d !== 8'h02) begin errors++; $display("FAIL hyg_count: got %h expected 02", d); end
        bus_read(8'hC1, d, oe);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL hyg_status: got %h expected 00", d); end
        bus_idle(); #1;
        checks++; if ({tx_valid, tx_data} !== {1'b1, 8'h55}) begin errors++; $display("FAIL hyg_head: got %h expected 155", {tx_valid, tx_data}); end
        @(negedge clk);
        bus_addr = 8'hC0; bus_we = 1'b0; #1;
        checks++; if (bus_oe !== 1'b0) begin errors++; $display("FAIL hyg_lat_before: got %b expected 0", bus_oe); end
        @(posedge clk); #1;
        checks++; if ({bus_oe, bus_data} !== {1'b1, 8'h02}) begin errors++; $display("FAIL hyg_lat_after: got %h expected 102", {bus_oe, bus_data}); end
        @(negedge clk);
        bus_addr = 8'hC2; bus_we = 1'b1; tb_drv = 8'hEE; tb_drv_en = 1'b1; #1;
        checks++; if ({bus_oe, bus_data} !== {1'b0, 8'hEE}) begin errors++; $display("FAIL hyg_we_gate: got %h expected 0ee", {bus_oe, bus_data}); end
        @(posedge clk); #1;
        checks++; if (bus_oe !== 1'b0) begin errors++; $display("FAIL hyg_we_after: got %b expected 0", bus_oe); end
        bus_idle();
        @(negedge clk);
        bus_addr = 8'hC0; bus_we = 1'b0; tx_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus_data !== 8'h02) begin errors++; $display("FAIL hyg_pre_pop_read: got %h expected 02", bus_data); end
        @(negedge clk);
        tx_ready = 1'b0; bus_addr = 8'h00;
        bus_read(8'hC0, d, oe);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL hyg_post_pop_count: got %h expected 01", d); end
        checks++; if ({tx_valid, tx_data} !== {1'b1, 8'h66}) begin errors++; $display("FAIL hyg_post_pop_head: got %h expected 166", {tx_valid, tx_data}); end
        bus_write(8'hC1, 8'h01);
        bus_idle();
    endtask

    initial begin
        test_reset();
        test_ordering();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_bus_hygiene();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
